// File: rtl/dma_io_reader_if.sv
// Bus bundle between the DMA reader, the IO device data port, the CPU bus
// arbiter and the memory write port.
interface dma_io_reader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              io_cs;
  logic              io_write;
  logic [DATA_W-1:0] io_data;
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ack;

  // DMA channel side
  modport master (
    output io_cs, io_write, bus_req, mem_addr, mem_wdata, mem_we,
    input  io_data, bus_grant, mem_ack
  );

  // Device / arbiter / memory side
  modport slave (
    input  io_cs, io_write, bus_req, mem_addr, mem_wdata, mem_we,
    output io_data, bus_grant, mem_ack
  );
endinterface

// File: rtl/dma_io_reader.sv
// DMA channel that drains the IO device buffer into consecutive memory words.
module dma_io_reader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 31,
  parameter int unsigned CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              io_gpio,
  dma_io_reader_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            state;
  logic              io_cs_q;
  logic              io_write_q;
  logic              bus_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  len_reg;

  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_word;
  logic              grant_lost;

  // Burst length clamp, post-ack count and end-of-burst / grant-loss conditions
  assign len_eff    = ((cfg_len == '0) || (cfg_len > MAX_CNT)) ? MAX_CNT : cfg_len;
  assign cnt_inc    = xfer_count + CNT_W'(1);
  assign last_word  = (cnt_inc == len_reg) || !io_gpio || !cfg_en;
  assign grant_lost = !bus.bus_grant &&
                      ((state == S_RD) || (state == S_CAP) || (state == S_WR));

  assign bus.io_cs     = io_cs_q;
  assign bus.io_write  = io_write_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Burst sequencer; every output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      io_cs_q     <= 1'b0;
      io_write_q  <= 1'b1;
      bus_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_reg    <= '0;
      len_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      xfer_count  <= '0;
    end else begin
      done <= 1'b0;
      if (grant_lost) begin
        // An ack landing with the grant loss still counts: memory took the word
        if ((state == S_WR) && bus.mem_ack) begin
          xfer_count <= cnt_inc;
          addr_reg   <= addr_reg + ADDR_W'(1);
        end
        state      <= S_DONE;
        err        <= 1'b1;
        io_cs_q    <= 1'b0;
        io_write_q <= 1'b1;
        mem_we_q   <= 1'b0;
        bus_req_q  <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_en && io_gpio) begin
              state      <= S_REQ;
              bus_req_q  <= 1'b1;
              busy       <= 1'b1;
              addr_reg   <= cfg_base;
              len_reg    <= len_eff;
              xfer_count <= '0;
              err        <= 1'b0;
            end
          end
          S_REQ: begin
            if (bus.bus_grant) begin
              state      <= S_RD;
              io_cs_q    <= 1'b1;
              io_write_q <= 1'b0;
            end
          end
          S_RD: begin
            state <= S_CAP;
          end
          S_CAP: begin
            state       <= S_WR;
            io_cs_q     <= 1'b0;
            io_write_q  <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_reg;
            mem_wdata_q <= bus.io_data;
          end
          S_WR: begin
            if (bus.mem_ack) begin
              mem_we_q   <= 1'b0;
              xfer_count <= cnt_inc;
              addr_reg   <= addr_reg + ADDR_W'(1);
              if (last_word) begin
                state     <= S_DONE;
                bus_req_q <= 1'b0;
                done      <= 1'b1;
              end else begin
                state      <= S_RD;
                io_cs_q    <= 1'b1;
                io_write_q <= 1'b0;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_io_reader.sv
// Randomized bench for dma_io_reader with device, arbiter and memory models.
module tb_dma_io_reader;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned MAXW   = 31;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_en;
  logic [ADDR_W-1:0] cfg_base;
  logic [CNT_W-1:0]  cfg_len;
  logic              io_gpio;
  logic              busy, done, err;
  logic [CNT_W-1:0]  xfer_count;

  dma_io_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dma_io_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .io_gpio(io_gpio), .bus(bus), .busy(busy), .done(done), .err(err),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // environment state
  logic [DATA_W-1:0] dev_words[$];
  int dev_ptr, dev_limit, reads, cs_run;
  int req_wait, grant_delay, grant_cycle, req_cycle, first_cs_cycle, cs_before_grant;
  int drop_grant_read, grant_dropped, en_drop_read, proto_err;
  int we_wait, cur_delay, ack_d0, ack_max, stab_err, done_cnt;
  logic [ADDR_W-1:0] we_addr0;
  logic [DATA_W-1:0] we_data0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int wr_cyc[$];

  // device, arbiter and memory models, all acting mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.io_cs && bus.io_write !== 1'b0) proto_err++;
      if (bus.io_cs) begin
        if (grant_cycle < 0) cs_before_grant++;
        if (cs_run == 0) begin
          bus.io_data = (dev_ptr < dev_words.size()) ? dev_words[dev_ptr] : '0;
          dev_ptr++;
          reads++;
          if (first_cs_cycle < 0) first_cs_cycle = cyc;
          if (dev_limit != 0 && reads == dev_limit) io_gpio = 1'b0;
          if (en_drop_read != 0 && reads == en_drop_read) cfg_en = 1'b0;
        end else if (drop_grant_read != 0 && reads == drop_grant_read) begin
          bus.bus_grant = 1'b0;
          grant_dropped = 1;
        end
        cs_run++;
      end else begin
        cs_run = 0;
      end

      if (bus.bus_req) begin
        if (req_cycle < 0) req_cycle = cyc;
        if (grant_dropped == 0 && bus.bus_grant !== 1'b1) begin
          if (req_wait >= grant_delay) begin
            bus.bus_grant = 1'b1;
            if (grant_cycle < 0) grant_cycle = cyc;
          end else begin
            req_wait++;
          end
        end
      end else begin
        bus.bus_grant = 1'b0;
        req_wait = 0;
        grant_dropped = 0;
      end

      if (bus.mem_we) begin
        if (we_wait == 0) begin
          cur_delay = (wr_addr.size() == 0) ? ack_d0 : int'($urandom_range(ack_max, 0));
          we_addr0 = bus.mem_addr;
          we_data0 = bus.mem_wdata;
        end else if (bus.mem_addr !== we_addr0 || bus.mem_wdata !== we_data0) begin
          stab_err++;
        end
        if (we_wait >= cur_delay) begin
          bus.mem_ack = 1'b1;
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
          wr_cyc.push_back(cyc);
        end else begin
          bus.mem_ack = 1'b0;
        end
        we_wait++;
      end else begin
        bus.mem_ack = 1'b0;
        we_wait = 0;
      end

      if (done) done_cnt++;
    end
  end

  // words a burst must move: clamped length, cut short by the device running dry
  function automatic int exp_words(input logic [CNT_W-1:0] len, input int limit);
    int l;
    l = (len == 0) ? int'(MAXW) : ((int'(len) > int'(MAXW)) ? int'(MAXW) : int'(len));
    if (limit != 0 && limit < l) return limit;
    return l;
  endfunction

  task automatic setup_burst(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] len,
                             input int limit);
    dev_words.delete();
    for (int i = 0; i < 40; i++) dev_words.push_back($urandom);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    dev_ptr = 0; reads = 0; cs_run = 0; dev_limit = limit;
    req_cycle = -1; grant_cycle = -1; first_cs_cycle = -1; cs_before_grant = 0;
    stab_err = 0; done_cnt = 0; proto_err = 0; we_wait = 0;
    cfg_base = base; cfg_len = len; io_gpio = 1'b1; cfg_en = 1'b1;
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        cfg_en = 1'b0;
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.io_cs !== 1'b0) begin errors++; $display("FAIL rst_io_cs got %b exp 0", bus.io_cs); end
    checks++; if (bus.io_write !== 1'b1) begin errors++; $display("FAIL rst_io_write got %b exp 1", bus.io_write); end
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b exp 0", bus.bus_req); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin errors++;
      $display("FAIL rst_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_status got %b exp 000", {busy, done, err}); end
    checks++; if (xfer_count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", xfer_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    setup_burst(32'h100, 5'd0, 4);
    for (int i = 0; i < 4; i++) dev_words[i] = 32'hA0 + 32'(i);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
    checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL basic_nwrites got %0d exp 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 32'h100 + 32'(i) || wr_data[i] !== 32'hA0 + 32'(i)) begin errors++;
        $display("FAIL basic_write%0d got %h:%h exp %h:%h", i, wr_addr[i], wr_data[i],
                 32'h100 + 32'(i), 32'hA0 + 32'(i)); end
      if (i > 0) begin
        checks++; if (wr_cyc[i] - wr_cyc[i-1] != 3) begin errors++;
          $display("FAIL basic_spacing%0d got %0d exp 3", i, wr_cyc[i] - wr_cyc[i-1]); end
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt); end
    checks++; if (xfer_count !== 5'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", xfer_count); end
    checks++; if (bus.bus_req !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL basic_idle got req=%b busy=%b exp 0/0", bus.bus_req, busy); end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL basic_iowrite got %0d exp 0", proto_err); end
  endtask

  task automatic test_len_rearm();
    bit to, ok, ok2;
    int bad;
    logic [ADDR_W-1:0] base;
    base = $urandom;
    setup_burst(base, 5'd2, 0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin @(negedge clk); if (done) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL rearm_first_done got timeout exp done"); end
    ok2 = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.bus_req) begin ok2 = 1'b1; break; end end
    checks++; if (!ok2) begin errors++; $display("FAIL rearm_restart got no req exp req"); end
    checks++; if (xfer_count !== '0) begin errors++; $display("FAIL rearm_count_clear got %0d exp 0", xfer_count); end
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL rearm_timeout got timeout exp done"); end
    checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL rearm_nwrites got %0d exp 4", wr_addr.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== base + 32'(i % 2) || wr_data[i] !== dev_words[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rearm_writes got %0d bad exp 0", bad); end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL rearm_done got %0d exp 2", done_cnt); end
    checks++; if (xfer_count !== 5'd2) begin errors++; $display("FAIL rearm_count got %0d exp 2", xfer_count); end
  endtask

  task automatic test_grant_wait();
    bit to;
    grant_delay = 5;
    setup_burst($urandom, 5'd3, 0);
    wait_done(to);
    grant_delay = 0;
    checks++; if (to) begin errors++; $display("FAIL gwait_timeout got timeout exp done"); end
    checks++; if (grant_cycle - req_cycle != 5) begin errors++;
      $display("FAIL gwait_hold got %0d exp 5", grant_cycle - req_cycle); end
    checks++; if (cs_before_grant != 0) begin errors++; $display("FAIL gwait_cs got %0d exp 0", cs_before_grant); end
    checks++; if (first_cs_cycle - grant_cycle != 1) begin errors++;
      $display("FAIL gwait_rd_lat got %0d exp 1", first_cs_cycle - grant_cycle); end
    checks++; if (wr_addr.size() != 3) begin errors++; $display("FAIL gwait_nwrites got %0d exp 3", wr_addr.size()); end
  endtask

  task automatic test_ack_delay();
    bit to;
    ack_d0 = 3;
    setup_burst($urandom, 5'd3, 0);
    wait_done(to);
    ack_d0 = 0;
    checks++; if (to) begin errors++; $display("FAIL ack_timeout got timeout exp done"); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL ack_stable got %0d exp 0", stab_err); end
    checks++; if (reads != 3 || wr_addr.size() != 3) begin errors++;
      $display("FAIL ack_counts got reads=%0d writes=%0d exp 3/3", reads, wr_addr.size()); end
    if (wr_cyc.size() >= 2) begin
      checks++; if (wr_cyc[0] - first_cs_cycle != 5) begin errors++;
        $display("FAIL ack_word1_lat got %0d exp 5", wr_cyc[0] - first_cs_cycle); end
      checks++; if (wr_cyc[1] - wr_cyc[0] != 3) begin errors++;
        $display("FAIL ack_word2_lat got %0d exp 3", wr_cyc[1] - wr_cyc[0]); end
    end
  endtask

  task automatic test_grant_loss();
    bit to;
    drop_grant_read = 2;
    setup_burst($urandom, 5'd0, 0);
    wait_done(to);
    drop_grant_read = 0;
    checks++; if (to) begin errors++; $display("FAIL gloss_timeout got timeout exp done"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL gloss_err got %b exp 1", err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL gloss_done got %0d exp 1", done_cnt); end
    checks++; if (xfer_count !== 5'd1) begin errors++; $display("FAIL gloss_count got %0d exp 1", xfer_count); end
    checks++; if (wr_addr.size() != 1 || reads != 2) begin errors++;
      $display("FAIL gloss_traffic got writes=%0d reads=%0d exp 1/2", wr_addr.size(), reads); end
  endtask

  task automatic test_wrap();
    bit to;
    setup_burst(32'hFFFF_FFFF, 5'd2, 0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got timeout exp done"); end
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL wrap_nwrites got %0d exp 2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 32'hFFFF_FFFF || wr_addr[1] !== 32'h0) begin errors++;
        $display("FAIL wrap_addr got %h,%h exp ffffffff,00000000", wr_addr[0], wr_addr[1]); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", err); end
  endtask

  task automatic test_en_drop();
    bit to;
    en_drop_read = 3;
    setup_burst($urandom, 5'd0, 0);
    wait_done(to);
    en_drop_read = 0;
    checks++; if (to) begin errors++; $display("FAIL endrop_timeout got timeout exp done"); end
    checks++; if (wr_addr.size() != 3 || xfer_count !== 5'd3) begin errors++;
      $display("FAIL endrop_count got writes=%0d count=%0d exp 3/3", wr_addr.size(), xfer_count); end
  endtask

  task automatic test_random();
    bit to;
    int n, bad, lim;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0] len;
    ack_max = 2;
    for (int b = 0; b < 8; b++) begin
      base = $urandom;
      len = CNT_W'($urandom_range(31, 0));
      lim = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(35, 1));
      grant_delay = int'($urandom_range(3, 0));
      setup_burst(base, len, lim);
      wait_done(to);
      n = exp_words(len, lim);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got timeout exp done", b); end
      checks++; if (wr_addr.size() != n || reads != n) begin errors++;
        $display("FAIL rand%0d_nwrites got %0d/%0d exp %0d", b, wr_addr.size(), reads, n); end
      bad = 0;
      for (int i = 0; i < wr_addr.size(); i++)
        if (wr_addr[i] !== base + 32'(i) || wr_data[i] !== dev_words[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_data got %0d bad exp 0", b, bad); end
      checks++; if (int'(xfer_count) != n) begin errors++;
        $display("FAIL rand%0d_count got %0d exp %0d", b, xfer_count, n); end
      checks++; if (done_cnt != 1 || err !== 1'b0 || stab_err != 0) begin errors++;
        $display("FAIL rand%0d_status got done=%0d err=%b stab=%0d exp 1/0/0", b, done_cnt, err, stab_err); end
    end
    ack_max = 0;
    grant_delay = 0;
  endtask

  task automatic test_reset_mid_wr();
    bit ok;
    setup_burst($urandom, 5'd0, 0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.mem_we && xfer_count == 5'd1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstwr_reach got timeout exp word2 write"); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.bus_req !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rstwr_async got we=%b req=%b busy=%b exp 000", bus.mem_we, bus.bus_req, busy); end
    checks++; if (xfer_count !== '0 || bus.io_cs !== 1'b0) begin errors++;
      $display("FAIL rstwr_count got %0d cs=%b exp 0/0", xfer_count, bus.io_cs); end
    cfg_en = 1'b0;
    bus.mem_ack = 1'b0;
    bus.bus_grant = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    cfg_en = 1'b0; cfg_base = '0; cfg_len = '0; io_gpio = 1'b0;
    bus.io_data = '0; bus.bus_grant = 1'b0; bus.mem_ack = 1'b0;
    dev_ptr = 0; dev_limit = 0; reads = 0; cs_run = 0; req_wait = 0; grant_delay = 0;
    grant_cycle = -1; req_cycle = -1; first_cs_cycle = -1; cs_before_grant = 0;
    drop_grant_read = 0; grant_dropped = 0; en_drop_read = 0; proto_err = 0;
    we_wait = 0; cur_delay = 0; ack_d0 = 0; ack_max = 0; stab_err = 0; done_cnt = 0;
    we_addr0 = '0; we_data0 = '0;
    test_reset();
    test_basic();
    test_len_rearm();
    test_grant_wait();
    test_ack_delay();
    test_grant_loss();
    test_wrap();
    test_en_drop();
    test_random();
    test_reset_mid_wr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
